// File: rtl/result_capture_fifo.sv
// result_capture_fifo: first-word-fall-through byte FIFO that also keeps a running checksum,
// a saturating acceptance count and a sticky zero-byte flag over accepted results.
module result_capture_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              checksum,
  output logic [7:0]               accept_cnt,
  output logic                     zero_seen
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  // A pop while full does not open a slot in the same cycle.
  assign in_ready  = level != FULL;
  assign out_valid = level != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= in_data;
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      checksum   <= 16'h0000;
      accept_cnt <= 8'h00;
      zero_seen  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= (push && !pop) ? level + ONE : (!push && pop) ? level - ONE : level;
      if (push) checksum <= checksum + {8'h00, in_data};
      if (push && accept_cnt != 8'hFF) accept_cnt <= accept_cnt + 8'd1;
      if (push && in_data == 8'h00) zero_seen <= 1'b1;
    end
  end
endmodule

// File: tb/tb_result_capture_fifo.sv
// tb_result_capture_fifo: directed and randomized checks of result_capture_fifo against a queue model.
module tb_result_capture_fifo;
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] checksum;
  logic [7:0]  accept_cnt;
  logic        zero_seen;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];
  int m_sum;
  int m_cnt;
  bit m_zero;

  result_capture_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clear(clear), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .checksum(checksum), .accept_cnt(accept_cnt), .zero_seen(zero_seen)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    q.delete();
    m_sum = 0;
    m_cnt = 0;
    m_zero = 0;
  endtask

  // Apply one clock of stimulus and advance the model by the FIFO's rules.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    bit do_push, do_pop;
    in_valid = v;
    in_data = d;
    out_ready = r;
    do_push = v && q.size() < DEPTH;
    do_pop = r && q.size() > 0;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back(d);
      m_sum = (m_sum + int'(d)) % 65536;
      if (m_cnt < 255) m_cnt++;
      if (d == 8'h00) m_zero = 1;
    end
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    #2 clear = 1'b1;
    #1 clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (level !== '0 || out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1 ||
        checksum !== 16'h0000 || accept_cnt !== 8'h00 || zero_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: level=%0d ov=%b od=%h ir=%b ck=%h cnt=%0d z=%b", level, out_valid, out_data, in_ready, checksum, accept_cnt, zero_seen);
    end
    in_valid = 1'b1;
    in_data = 8'h99;
    @(posedge clk);
    #1;
    vectors++;
    if (level !== '0 || checksum !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_blocks_push: level=%0d ck=%h want 0/0000", level, checksum);
    end
    in_valid = 1'b0;
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp[i]) cycle(1'b1, exp[i], 1'b0);
    vectors++;
    if (level !== 3'd4 || in_ready !== 1'b0 || checksum !== 16'h00AA) begin
      miscompares++;
      $display("FAIL fill: level=%0d ir=%b ck=%h want 4/0/00aa", level, in_ready, checksum);
    end
    foreach (exp[i]) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        miscompares++;
        $display("FAIL drain[%0d]: ov=%b od=%h want 1/%h", i, out_valid, out_data, exp[i]);
      end
      cycle(1'b0, 8'h00, 1'b1);
    end
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== '0) begin
      miscompares++;
      $display("FAIL drained: ov=%b od=%h level=%0d want 0/00/0", out_valid, out_data, level);
    end
  endtask

  task automatic test_backpressure();
    pulse_clear();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    vectors++;
    if (level !== 3'd3 || accept_cnt !== 8'd4 || out_data !== 8'h22 || checksum !== 16'h00AA) begin
      miscompares++;
      $display("FAIL full_backpressure: level=%0d cnt=%0d od=%h ck=%h want 3/4/22/00aa", level, accept_cnt, out_data, checksum);
    end
  endtask

  task automatic test_simultaneous();
    pulse_clear();
    cycle(1'b1, 8'hA0, 1'b0);
    vectors++;
    if (level !== 3'd1 || out_data !== 8'hA0) begin
      miscompares++;
      $display("FAIL simul_setup: level=%0d od=%h want 1/a0", level, out_data);
    end
    cycle(1'b1, 8'hB0, 1'b1);
    vectors++;
    if (level !== 3'd1 || out_data !== 8'hB0) begin
      miscompares++;
      $display("FAIL simul_push_pop: level=%0d od=%h want 1/b0", level, out_data);
    end
  endtask

  task automatic test_wrap_saturation();
    int bad = 0;
    pulse_clear();
    cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 1; i < 300; i++) begin
      cycle(1'b1, 8'hFF, 1'b1);
      if (level !== 3'd1 || out_data !== 8'hFF) bad++;
    end
    cycle(1'b0, 8'h00, 1'b1);
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL wrap_stream: %0d cycles with level!=1 or out_data!=ff", bad);
    end
    vectors++;
    if (accept_cnt !== 8'd255 || checksum !== 16'h2AD4 || level !== '0) begin
      miscompares++;
      $display("FAIL saturation: cnt=%0d ck=%h level=%0d want 255/2ad4/0", accept_cnt, checksum, level);
    end
  endtask

  task automatic test_zero();
    pulse_clear();
    cycle(1'b1, 8'h05, 1'b0);
    vectors++;
    if (zero_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_idle: zero_seen=%b want 0", zero_seen);
    end
    cycle(1'b1, 8'h00, 1'b1);
    vectors++;
    if (zero_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_set: zero_seen=%b want 1", zero_seen);
    end
    cycle(1'b1, 8'h01, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    vectors++;
    if (zero_seen !== 1'b1 || level !== '0) begin
      miscompares++;
      $display("FAIL zero_sticky: zero_seen=%b level=%0d want 1/0", zero_seen, level);
    end
  endtask

  task automatic test_async_clear();
    pulse_clear();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    vectors++;
    if (level !== 3'd3) begin
      miscompares++;
      $display("FAIL async_setup: level=%0d want 3", level);
    end
    #2 clear = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || level !== '0 || checksum !== 16'h0000 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL async_clear: ov=%b level=%0d ck=%h ir=%b od=%h want 0/0/0000/1/00", out_valid, level, checksum, in_ready, out_data);
    end
    clear = 1'b0;
    model_clear();
    cycle(1'b1, 8'h7E, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h7E || level !== 3'd1) begin
      miscompares++;
      $display("FAIL after_clear_push: ov=%b od=%h level=%0d want 1/7e/1", out_valid, out_data, level);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] exp_od;
    pulse_clear();
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cycle(1'($urandom_range(0, 99) < 60), d, 1'($urandom_range(0, 99) < 50));
      exp_od = q.size() > 0 ? q[0] : 8'h00;
      vectors++;
      if (int'(level) != q.size() || out_data !== exp_od || out_valid !== (q.size() > 0) ||
          in_ready !== (q.size() < DEPTH) || checksum !== 16'(m_sum) || accept_cnt !== 8'(m_cnt) ||
          zero_seen !== m_zero) begin
        miscompares++;
        $display("FAIL random[%0d]: level=%0d/%0d od=%h/%h ck=%h/%h cnt=%0d/%0d z=%b/%b",
                 i, level, q.size(), out_data, exp_od, checksum, 16'(m_sum), accept_cnt, m_cnt, zero_seen, m_zero);
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_simultaneous();
    test_wrap_saturation();
    test_zero();
    test_async_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
